// File: rtl/pe_pkg.sv
// Shared widths and the saturating fit helper for the weight-stationary PE.
package pe_pkg;

    localparam int DATA_W_DEF = 16;
    localparam int W_W_DEF    = 16;
    localparam int PSUM_W_DEF = 16;

    // Container width for the full-precision sum; must exceed max(DATA_W+W_W, PSUM_W)+1.
    localparam int FIT_W = 64;

    // Fits a full-width sum into psum_w bits. The caller keeps the low psum_w bits,
    // so returning the sum unchanged is the wrap behaviour.
    function automatic logic signed [FIT_W-1:0] sat_fit(
        input  logic signed [FIT_W-1:0] sum,
        input  int                      psum_w,
        input  logic                    saturate,
        output logic                    ovf
    );
        logic signed [FIT_W-1:0] hi;
        logic signed [FIT_W-1:0] lo;
        hi  = (64'sd1 <<< (psum_w - 1)) - 64'sd1;
        lo  = -hi - 64'sd1;
        ovf = (sum > hi) || (sum < lo);
        if (saturate && (sum > hi)) begin
            return hi;
        end
        if (saturate && (sum < lo)) begin
            return lo;
        end
        return sum;
    endfunction

endpackage

// File: rtl/pe_sat_add.sv
// Combinational multiply-accumulate: psum + iact*weight at full precision, then fit.
// No registers; overflow reflects the full-precision sum in either fit mode.
module pe_sat_add
    import pe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int W_W      = W_W_DEF,
    parameter int PSUM_W   = PSUM_W_DEF,
    parameter int SATURATE = 1
) (
    input  logic signed [DATA_W-1:0] iact,
    input  logic signed [W_W-1:0]    weight,
    input  logic signed [PSUM_W-1:0] psum,
    output logic signed [PSUM_W-1:0] sum,
    output logic                     ovf
);

    localparam int PROD_W = DATA_W + W_W;
    localparam int SUM_W  = ((PROD_W > PSUM_W) ? PROD_W : PSUM_W) + 1;

    logic signed [PROD_W-1:0] iact_ext;
    logic signed [PROD_W-1:0] weight_ext;
    logic signed [PROD_W-1:0] prod;
    logic signed [SUM_W-1:0]  sum_wide;
    logic signed [FIT_W-1:0]  fitted;
    logic                     fit_ovf;
    logic                     unused_fit_hi;

    assign iact_ext   = PROD_W'(iact);
    assign weight_ext = PROD_W'(weight);
    assign prod       = iact_ext * weight_ext;
    assign sum_wide   = SUM_W'(prod) + SUM_W'(psum);

    always_comb begin
        fit_ovf = 1'b0;
        fitted  = sat_fit(FIT_W'(sum_wide), PSUM_W, (SATURATE != 0), fit_ovf);
    end

    assign sum           = fitted[PSUM_W-1:0];
    assign ovf           = fit_ovf;
    assign unused_fit_hi = ^fitted[FIT_W-1:PSUM_W];

endmodule

// File: rtl/pe_ws.sv
// Weight-stationary PE: registered MAC cell with a double-buffered (shadow/active) weight.
// Datapath latency 1 cycle; en=0 freezes the datapath, the weight chain runs regardless.
module pe_ws
    import pe_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int W_W      = W_W_DEF,
    parameter int PSUM_W   = PSUM_W_DEF,
    parameter int SATURATE = 1
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     en,
    input  logic                     bypass,
    input  logic signed [DATA_W-1:0] iact_in,
    input  logic                     iact_valid_in,
    input  logic signed [PSUM_W-1:0] psum_in,
    output logic signed [DATA_W-1:0] iact_out,
    output logic                     iact_valid_out,
    output logic signed [PSUM_W-1:0] psum_out,
    output logic                     psum_valid_out,
    input  logic                     w_shift,
    input  logic signed [W_W-1:0]    w_in,
    output logic signed [W_W-1:0]    w_out,
    input  logic                     w_swap,
    output logic                     w_ready,
    output logic                     w_active,
    output logic                     ovf,
    input  logic                     clear_ovf
);

    logic signed [W_W-1:0]    shadow_w;
    logic signed [W_W-1:0]    active_w;
    logic signed [PSUM_W-1:0] mac_sum;
    logic                     mac_ovf;
    logic                     swap_ok;
    logic                     advance;

    assign swap_ok = w_swap && w_ready;
    assign advance = en && iact_valid_in;
    assign w_out   = shadow_w;

    pe_sat_add #(
        .DATA_W   (DATA_W),
        .W_W      (W_W),
        .PSUM_W   (PSUM_W),
        .SATURATE (SATURATE)
    ) u_sat_add (
        .iact   (iact_in),
        .weight (active_w),
        .psum   (psum_in),
        .sum    (mac_sum),
        .ovf    (mac_ovf)
    );

    // A simultaneous shift refills the shadow as it is swapped out, so w_ready stays set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            shadow_w <= '0;
            active_w <= '0;
            w_ready  <= 1'b0;
            w_active <= 1'b0;
        end else begin
            if (swap_ok) begin
                active_w <= shadow_w;
                w_active <= 1'b1;
            end
            if (w_shift) begin
                shadow_w <= w_in;
                w_ready  <= 1'b1;
            end else if (swap_ok) begin
                w_ready  <= 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iact_out       <= '0;
            iact_valid_out <= 1'b0;
            psum_out       <= '0;
            psum_valid_out <= 1'b0;
        end else if (en) begin
            iact_valid_out <= iact_valid_in;
            psum_valid_out <= iact_valid_in;
            if (iact_valid_in) begin
                iact_out <= iact_in;
                psum_out <= bypass ? psum_in : mac_sum;
            end
        end
    end

    // Set has priority over clear so a same-cycle overflow is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ovf <= 1'b0;
        end else if (advance && !bypass && mac_ovf) begin
            ovf <= 1'b1;
        end else if (clear_ovf) begin
            ovf <= 1'b0;
        end
    end

endmodule
